// File: rtl/step_phase_decoder.sv
// Receive-side stepper decoder: rebuilds signed position, direction and fault status from the coil drive lines.
// Optional stall watchdog is built only when STEP_PHASE_STALL_EN is defined.
module step_phase_decoder #(
  parameter int WIDTH         = 14,
  parameter int STABLE_CYCLES = 4,
  parameter int STALL_CYCLES  = 2000000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    A1,
  input  logic                    B1,
  input  logic                    A2,
  input  logic                    B2,
  input  logic                    clear,
  input  logic                    load_target,
  input  logic signed [WIDTH-1:0] target,
  output logic signed [WIDTH-1:0] position,
  output logic                    dir,
  output logic                    step_pulse,
  output logic                    hit,
  output logic                    at_target,
  output logic                    error,
  output logic                    stall
);

  typedef enum logic [0:0] {
    NOREF = 1'b0,
    TRACK = 1'b1
  } state_t;

  localparam logic [7:0] STABLE_LIM = 8'(STABLE_CYCLES);

  logic [3:0]              meta_r, sync_r, cand_r, acc_pat_r;
  logic [7:0]              cnt_r;
  logic                    acc_valid_r;

  state_t                  state_r, state_nxt_s;
  logic [1:0]              last_phase_r, last_phase_nxt_s;
  logic signed [WIDTH-1:0] position_r, position_nxt_s;
  logic signed [WIDTH-1:0] target_q_r, target_nxt_s;
  logic                    dir_r, dir_nxt_s;
  logic                    error_r, error_nxt_s;
  logic                    step_pulse_r, step_s;
  logic                    hit_r, hit_nxt_s;
  logic                    at_target_r, at_target_nxt_s;

  logic [1:0]              phase_idx_s;
  logic                    is_phase_s, is_off_s;
  logic [1:0]              phase_diff_s;

  // Two-flop synchronizer for the asynchronous coil nibble {A1,B1,A2,B2}.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_r <= 4'b0000;
      sync_r <= 4'b0000;
    end else begin
      meta_r <= {A1, B1, A2, B2};
      sync_r <= meta_r;
    end
  end

  // Stability filter: a pattern is accepted once, after STABLE_CYCLES equal samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cand_r      <= 4'b0000;
      cnt_r       <= 8'd0;
      acc_valid_r <= 1'b0;
      acc_pat_r   <= 4'b0000;
    end else begin
      acc_valid_r <= 1'b0;
      if (sync_r != cand_r) begin
        cand_r <= sync_r;
        cnt_r  <= 8'd1;
        if (STABLE_LIM == 8'd1) begin
          acc_valid_r <= 1'b1;
          acc_pat_r   <= sync_r;
        end
      end else if (cnt_r < STABLE_LIM) begin
        cnt_r <= cnt_r + 8'd1;
        if (cnt_r + 8'd1 == STABLE_LIM) begin
          acc_valid_r <= 1'b1;
          acc_pat_r   <= cand_r;
        end
      end
    end
  end

  // Classify the accepted pattern into phase index, OFF or illegal.
  always_comb begin
    phase_idx_s = 2'd0;
    is_phase_s  = 1'b0;
    is_off_s    = 1'b0;
    case (acc_pat_r)
      4'b1100: begin phase_idx_s = 2'd0; is_phase_s = 1'b1; end
      4'b0110: begin phase_idx_s = 2'd1; is_phase_s = 1'b1; end
      4'b0011: begin phase_idx_s = 2'd2; is_phase_s = 1'b1; end
      4'b1001: begin phase_idx_s = 2'd3; is_phase_s = 1'b1; end
      4'b0000: begin is_off_s = 1'b1; end
      default: begin is_phase_s = 1'b0; end
    endcase
  end

  // Modulo-4 distance: 1 = next phase, 3 = previous phase, 2 = opposite phase.
  assign phase_diff_s = phase_idx_s - last_phase_r;

  // Tracker next-state and output logic; clear overrides any step in the same cycle.
  always_comb begin
    state_nxt_s      = state_r;
    last_phase_nxt_s = last_phase_r;
    position_nxt_s   = position_r;
    dir_nxt_s        = dir_r;
    error_nxt_s      = error_r;
    step_s           = 1'b0;
    if (clear) begin
      state_nxt_s      = NOREF;
      last_phase_nxt_s = 2'd0;
      position_nxt_s   = '0;
      dir_nxt_s        = 1'b0;
      error_nxt_s      = 1'b0;
    end else if (acc_valid_r) begin
      if (!is_phase_s && !is_off_s) begin
        error_nxt_s = 1'b1;
      end else if (is_off_s) begin
        state_nxt_s = state_r;
      end else if (state_r == NOREF) begin
        state_nxt_s      = TRACK;
        last_phase_nxt_s = phase_idx_s;
      end else begin
        case (phase_diff_s)
          2'd1: begin
            position_nxt_s   = position_r + WIDTH'(1);
            dir_nxt_s        = 1'b1;
            step_s           = 1'b1;
            last_phase_nxt_s = phase_idx_s;
          end
          2'd3: begin
            position_nxt_s   = position_r - WIDTH'(1);
            dir_nxt_s        = 1'b0;
            step_s           = 1'b1;
            last_phase_nxt_s = phase_idx_s;
          end
          2'd2: begin
            error_nxt_s      = 1'b1;
            last_phase_nxt_s = phase_idx_s;
          end
          default: begin
            last_phase_nxt_s = last_phase_r;
          end
        endcase
      end
    end else begin
      step_s = 1'b0;
    end
  end

  assign target_nxt_s    = load_target ? target : target_q_r;
  assign at_target_nxt_s = (position_nxt_s == target_nxt_s);
  // Only a step can raise hit; equality created by load_target or clear stays silent.
  assign hit_nxt_s       = step_s & at_target_nxt_s & ~at_target_r;

  // Tracker state and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= NOREF;
      last_phase_r <= 2'd0;
      position_r   <= '0;
      target_q_r   <= '0;
      dir_r        <= 1'b0;
      error_r      <= 1'b0;
      step_pulse_r <= 1'b0;
      hit_r        <= 1'b0;
      at_target_r  <= 1'b1;
    end else begin
      state_r      <= state_nxt_s;
      last_phase_r <= last_phase_nxt_s;
      position_r   <= position_nxt_s;
      target_q_r   <= target_nxt_s;
      dir_r        <= dir_nxt_s;
      error_r      <= error_nxt_s;
      step_pulse_r <= step_s;
      hit_r        <= hit_nxt_s;
      at_target_r  <= at_target_nxt_s;
    end
  end

`ifdef STEP_PHASE_STALL_EN
  localparam logic [31:0] STALL_LIM = 32'(STALL_CYCLES);

  logic [31:0] stall_cnt_r;
  logic        stall_r;
  logic        stall_run_s;

  assign stall_run_s = (state_r == TRACK) && (acc_pat_r != 4'b0000) && !at_target_r;

  // Watchdog: counts while energized and off target; flag holds until a step or clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_r <= 32'd0;
      stall_r     <= 1'b0;
    end else begin
      if (clear || step_s || !stall_run_s) begin
        stall_cnt_r <= 32'd0;
      end else if (stall_cnt_r != STALL_LIM) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end
      if (clear || step_s) begin
        stall_r <= 1'b0;
      end else if (stall_run_s && (stall_cnt_r + 32'd1 == STALL_LIM)) begin
        stall_r <= 1'b1;
      end
    end
  end

  assign stall = stall_r;
`else
  assign stall = 1'b0;
`endif

  assign position   = position_r;
  assign dir        = dir_r;
  assign step_pulse = step_pulse_r;
  assign hit        = hit_r;
  assign at_target  = at_target_r;
  assign error      = error_r;

endmodule

// File: tb/tb_step_phase_decoder.sv
// Self-checking bench for step_phase_decoder: directed scenarios plus randomized phase sequences
// compared against a pattern-level position model.
module tb_step_phase_decoder;
  localparam int WIDTH = 14;

  logic clk = 1'b0;
  logic reset, A1, B1, A2, B2, clear, load_target;
  logic signed [WIDTH-1:0] target;
  logic signed [WIDTH-1:0] position;
  logic dir, step_pulse, hit, at_target, error, stall;

  step_phase_decoder #(.WIDTH(WIDTH), .STABLE_CYCLES(4), .STALL_CYCLES(100)) dut (
    .clk(clk), .reset(reset), .A1(A1), .B1(B1), .A2(A2), .B2(B2),
    .clear(clear), .load_target(load_target), .target(target),
    .position(position), .dir(dir), .step_pulse(step_pulse), .hit(hit),
    .at_target(at_target), .error(error), .stall(stall)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int step_cnt = 0;
  int hit_cnt = 0;

  // Count output pulses shortly after each active edge.
  always @(posedge clk) begin
    #2;
    if (step_pulse === 1'b1) step_cnt++;
    if (hit === 1'b1) hit_cnt++;
  end

  // Reference model: state of the motor as seen from whole accepted patterns.
  bit m_ref;
  int m_last;
  logic signed [WIDTH-1:0] m_pos, m_tgt;
  bit m_dir, m_err;
  int m_steps, m_hits;
  logic [3:0] pins;
  logic [3:0] ph [4];

  function automatic int pidx(input logic [3:0] p);
    case (p)
      4'b1100: return 0;
      4'b0110: return 1;
      4'b0011: return 2;
      4'b1001: return 3;
      4'b0000: return -1;
      default: return -2;
    endcase
  endfunction

  function automatic void model_apply(input logic [3:0] p);
    int i;
    int d;
    i = pidx(p);
    if (i == -2) m_err = 1'b1;
    else if (i == -1) m_err = m_err;
    else if (!m_ref) begin
      m_ref = 1'b1;
      m_last = i;
    end else begin
      d = (i - m_last + 4) % 4;
      if (d == 1) begin
        m_pos = m_pos + 14'sd1; m_dir = 1'b1; m_steps++;
        if (m_pos == m_tgt) m_hits++;
      end else if (d == 3) begin
        m_pos = m_pos - 14'sd1; m_dir = 1'b0; m_steps++;
        if (m_pos == m_tgt) m_hits++;
      end else if (d == 2) m_err = 1'b1;
      m_last = i;
    end
  endfunction

  task automatic set_pins(input logic [3:0] p);
    {A1, B1, A2, B2} = p;
  endtask

  task automatic drive(input logic [3:0] p, input int hold);
    set_pins(p);
    if (p != pins) model_apply(p);
    pins = p;
    repeat (hold) @(negedge clk);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    m_pos = '0; m_err = 1'b0; m_dir = 1'b0; m_ref = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_load(input logic signed [WIDTH-1:0] t);
    target = t;
    load_target = 1'b1;
    @(negedge clk);
    load_target = 1'b0;
    m_tgt = t;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({position, dir, step_pulse, hit, at_target, error, stall} !== {14'sd0, 6'b000100}) begin
      n_bad++;
      $display("FAIL reset_state: got pos=%0d dir=%b sp=%b hit=%b at=%b err=%b stall=%b, want 0/0/0/0/1/0/0",
               position, dir, step_pulse, hit, at_target, error, stall);
    end
    reset = 1'b0;
    repeat (10) @(negedge clk);
    n_cmp++;
    if (position !== 14'sd0 || step_cnt != 0) begin
      n_bad++;
      $display("FAIL reset_idle: got pos=%0d steps=%0d, want 0/0", position, step_cnt);
    end
  endtask

  task automatic test_forward();
    drive(ph[0], 10);
    set_pins(ph[1]); model_apply(ph[1]); pins = ph[1];
    repeat (6) @(negedge clk);
    n_cmp++;
    if (step_pulse !== 1'b0) begin
      n_bad++; $display("FAIL latency_early: got step_pulse=%b, want 0", step_pulse);
    end
    @(negedge clk);
    n_cmp++;
    if (step_pulse !== 1'b1 || position !== 14'sd1) begin
      n_bad++; $display("FAIL latency_edge: got sp=%b pos=%0d, want 1/1", step_pulse, position);
    end
    repeat (3) @(negedge clk);
    drive(ph[2], 10); drive(ph[3], 10); drive(ph[0], 10);
    n_cmp++;
    if (position !== m_pos || position !== 14'sd4 || dir !== 1'b1 || error !== 1'b0 || step_cnt != m_steps) begin
      n_bad++;
      $display("FAIL forward: got pos=%0d dir=%b err=%b steps=%0d, want %0d/1/0/%0d",
               position, dir, error, step_cnt, m_pos, m_steps);
    end
  endtask

  task automatic test_backward();
    do_clear();
    drive(4'b0000, 10); drive(ph[0], 10);
    drive(ph[3], 10); drive(ph[2], 10); drive(ph[1], 10);
    n_cmp++;
    if (position !== 14'sd0 - 14'sd3 || position !== m_pos || dir !== 1'b0 || step_cnt != m_steps) begin
      n_bad++;
      $display("FAIL backward: got pos=%0d dir=%b steps=%0d, want -3/0/%0d", position, dir, step_cnt, m_steps);
    end
    drive(4'b0000, 10); drive(ph[1], 10);
    n_cmp++;
    if (position !== m_pos || step_cnt != m_steps || error !== 1'b0) begin
      n_bad++;
      $display("FAIL off_transparent: got pos=%0d steps=%0d err=%b, want %0d/%0d/0",
               position, step_cnt, error, m_pos, m_steps);
    end
  endtask

  task automatic test_target();
    int h0;
    do_clear();
    do_load(14'sd2);
    n_cmp++;
    if (at_target !== 1'b0) begin
      n_bad++; $display("FAIL load_no_eq: got at_target=%b, want 0", at_target);
    end
    h0 = hit_cnt;
    drive(4'b0000, 10); drive(ph[0], 10); drive(ph[1], 10);
    set_pins(ph[2]); model_apply(ph[2]); pins = ph[2];
    repeat (7) @(negedge clk);
    n_cmp++;
    if (hit !== 1'b1 || position !== 14'sd2 || at_target !== 1'b1) begin
      n_bad++; $display("FAIL hit_edge: got hit=%b pos=%0d at=%b, want 1/2/1", hit, position, at_target);
    end
    repeat (10) @(negedge clk);
    n_cmp++;
    if (hit_cnt != h0 + 1 || at_target !== 1'b1 || hit_cnt - h0 != m_hits) begin
      n_bad++; $display("FAIL hit_once: got hits=%0d at=%b, want 1/1", hit_cnt - h0, at_target);
    end
    drive(ph[3], 10);
    n_cmp++;
    if (at_target !== 1'b0) begin
      n_bad++; $display("FAIL leave_target: got at_target=%b, want 0", at_target);
    end
    do_load(m_pos);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (at_target !== 1'b1 || hit_cnt != h0 + 1) begin
      n_bad++; $display("FAIL load_eq_no_hit: got at=%b hits=%0d, want 1/1", at_target, hit_cnt - h0);
    end
  endtask

  task automatic test_glitch_error();
    logic signed [WIDTH-1:0] p0;
    int s0;
    p0 = position; s0 = step_cnt;
    set_pins(ph[0]);
    repeat (3) @(negedge clk);
    set_pins(pins);
    repeat (12) @(negedge clk);
    n_cmp++;
    if (position !== p0 || step_cnt != s0) begin
      n_bad++; $display("FAIL glitch: got pos=%0d steps=%0d, want %0d/%0d", position, step_cnt, p0, s0);
    end
    drive(ph[0], 10); drive(ph[2], 10);
    n_cmp++;
    if (error !== 1'b1 || position !== m_pos || !m_err) begin
      n_bad++; $display("FAIL opposite_err: got err=%b pos=%0d, want 1/%0d", error, position, m_pos);
    end
    do_clear();
    n_cmp++;
    if (error !== 1'b0 || position !== 14'sd0 || dir !== 1'b0) begin
      n_bad++; $display("FAIL clear: got err=%b pos=%0d dir=%b, want 0/0/0", error, position, dir);
    end
    drive(ph[3], 10); drive(ph[0], 10);
    n_cmp++;
    if (position !== 14'sd1 || position !== m_pos) begin
      n_bad++; $display("FAIL noref_after_clear: got pos=%0d, want %0d", position, m_pos);
    end
    drive(4'b1010, 10);
    n_cmp++;
    if (error !== 1'b1 || position !== m_pos) begin
      n_bad++; $display("FAIL illegal_err: got err=%b pos=%0d, want 1/%0d", error, position, m_pos);
    end
    drive(ph[0], 10);
    do_clear();
  endtask

  task automatic test_wrap();
    int s0;
    drive(4'b0000, 10); drive(ph[0], 10);
    for (int i = 1; i <= 8191; i++) drive(ph[i % 4], 5);
    repeat (5) @(negedge clk);
    n_cmp++;
    if (position !== 14'sd8191 || position !== m_pos) begin
      n_bad++; $display("FAIL reach_max: got pos=%0d, want 8191", position);
    end
    drive(ph[0], 10);
    n_cmp++;
    if (position !== -14'sd8192 || position !== m_pos || dir !== 1'b1) begin
      n_bad++; $display("FAIL wrap: got pos=%0d dir=%b, want -8192/1", position, dir);
    end
    s0 = step_cnt;
    set_pins(ph[1]); pins = ph[1];
    repeat (6) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    m_pos = '0; m_err = 1'b0; m_dir = 1'b0; m_ref = 1'b0;
    n_cmp++;
    if (step_pulse !== 1'b0 || position !== 14'sd0) begin
      n_bad++; $display("FAIL clear_vs_step: got sp=%b pos=%0d, want 0/0", step_pulse, position);
    end
    repeat (5) @(negedge clk);
    n_cmp++;
    if (step_cnt != s0 || position !== 14'sd0) begin
      n_bad++; $display("FAIL clear_vs_step_after: got steps=%0d pos=%0d, want %0d/0", step_cnt, position, s0);
    end
  endtask

  task automatic test_random();
    int r;
    logic [3:0] p;
    logic signed [WIDTH-1:0] t;
    for (int it = 0; it < 80; it++) begin
      r = $urandom_range(0, 11);
      if (r <= 7) begin
        p = ph[$urandom_range(0, 3)];
        drive(p, $urandom_range(7, 10));
      end else if (r == 8) begin
        drive(4'b0000, $urandom_range(7, 10));
      end else if (r == 9 || r == 10) begin
        t = m_pos + 14'($urandom_range(0, 4)) - 14'sd2;
        do_load(t);
      end else begin
        do_clear();
      end
      n_cmp++;
      if (position !== m_pos || dir !== m_dir || error !== m_err || at_target !== (m_pos == m_tgt)
          || step_cnt != m_steps) begin
        n_bad++;
        $display("FAIL random_%0d: got pos=%0d dir=%b err=%b at=%b steps=%0d, want %0d/%b/%b/%b/%0d",
                 it, position, dir, error, at_target, step_cnt, m_pos, m_dir, m_err, m_pos == m_tgt, m_steps);
      end
`ifndef STEP_PHASE_STALL_EN
      n_cmp++;
      if (stall !== 1'b0) begin
        n_bad++; $display("FAIL stall_tied: got stall=%b, want 0", stall);
      end
`endif
    end
  endtask

  task automatic test_reset_mid();
    int s0;
    drive(ph[1], 10);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (position !== 14'sd0 || error !== 1'b0 || at_target !== 1'b1) begin
      n_bad++; $display("FAIL reset_mid: got pos=%0d err=%b at=%b, want 0/0/1", position, error, at_target);
    end
    reset = 1'b0;
    m_pos = '0; m_err = 1'b0; m_dir = 1'b0; m_ref = 1'b0; m_tgt = '0;
    model_apply(pins);
    repeat (10) @(negedge clk);
    s0 = step_cnt;
    drive(ph[2], 10);
    n_cmp++;
    if (position !== 14'sd1 || position !== m_pos || step_cnt != s0 + 1) begin
      n_bad++; $display("FAIL reref_after_reset: got pos=%0d steps=%0d, want 1/%0d", position, step_cnt, s0 + 1);
    end
  endtask

`ifdef STEP_PHASE_STALL_EN
  task automatic test_stall();
    do_clear();
    do_load(14'sd100);
    drive(4'b0000, 10); drive(ph[0], 10);
    set_pins(ph[1]); model_apply(ph[1]); pins = ph[1];
    repeat (7) @(negedge clk);
    repeat (98) @(negedge clk);
    n_cmp++;
    if (stall !== 1'b0) begin
      n_bad++; $display("FAIL stall_early: got stall=%b, want 0", stall);
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (stall !== 1'b1) begin
      n_bad++; $display("FAIL stall_set: got stall=%b, want 1", stall);
    end
    set_pins(ph[2]); model_apply(ph[2]); pins = ph[2];
    repeat (7) @(negedge clk);
    n_cmp++;
    if (stall !== 1'b0 || position !== m_pos) begin
      n_bad++; $display("FAIL stall_clear: got stall=%b pos=%0d, want 0/%0d", stall, position, m_pos);
    end
  endtask
`endif

  initial begin
    ph[0] = 4'b1100; ph[1] = 4'b0110; ph[2] = 4'b0011; ph[3] = 4'b1001;
    m_ref = 1'b0; m_last = 0; m_pos = '0; m_tgt = '0; m_dir = 1'b0; m_err = 1'b0;
    m_steps = 0; m_hits = 0; pins = 4'b0000;
    reset = 1'b1; clear = 1'b0; load_target = 1'b0; target = '0;
    set_pins(4'b0000);
    @(negedge clk);
    test_reset();
    test_forward();
    test_backward();
    test_target();
    test_glitch_error();
    test_wrap();
    test_random();
    test_reset_mid();
`ifdef STEP_PHASE_STALL_EN
    test_stall();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
